// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder: serialises the set bits of a request vector into binary indices, lowest first.
// Define ONEHOT_SCAN_MSB_FIRST_EN to scan from the highest set bit instead.
module onehot_scan_encoder #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic [W:0]   out_seq,
    output logic         zero_pulse
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state;
    logic [N-1:0] pending, nxt;
    logic accept, emit;
    function automatic logic [W-1:0] pick(input logic [N-1:0] v);
        pick = '0;
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
        for (int i = 0; i < N; i++) if (v[i]) pick = W'(i);
`else
        for (int i = N - 1; i >= 0; i--) if (v[i]) pick = W'(i);
`endif
    endfunction
    assign in_ready  = state == IDLE;
    assign out_valid = state == SCAN;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    // pending is always zero in IDLE, so accept and emit never overlap
    always_comb nxt = accept ? in_vec : emit ? pending & ~(N'(1) << out_idx) : pending;
    // index and last flag are registered from the next pending value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            out_seq    <= '0;
            zero_pulse <= 1'b0;
        end else begin
            state      <= |nxt ? SCAN : IDLE;
            pending    <= nxt;
            out_idx    <= pick(nxt);
            out_last   <= |nxt && (nxt & (nxt - N'(1))) == '0;
            out_seq    <= accept ? '0 : emit ? out_seq + 1'b1 : out_seq;
            zero_pulse <= accept & ~|in_vec;
        end
    end
endmodule

// File: tb/tb_onehot_scan_encoder.sv
// tb_onehot_scan_encoder: directed and random stimulus checked against a queue-based model of the index stream.
module tb_onehot_scan_encoder;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, out_ready = 0;
    logic [7:0] in_vec = '0;
    logic       in_ready, out_valid, out_last, zero_pulse;
    logic [2:0] out_idx;
    logic [3:0] out_seq;
    int n_cmp = 0, n_err = 0;
    int q[$];
    int seq = 0;
    bit zp_exp = 0;

    onehot_scan_encoder #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
        .out_seq(out_seq), .zero_pulse(zero_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        seq = 0;
        zp_exp = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] vec, input logic rdy);
        @(negedge clk);
        check("in_ready", in_ready, q.size() == 0);
        check("out_valid", out_valid, q.size() != 0);
        check("zero_pulse", zero_pulse, zp_exp);
        if (q.size() != 0) begin
            check("out_idx", out_idx, q[0]);
            check("out_last", out_last, q.size() == 1);
            check("out_seq", out_seq, seq);
        end
        in_valid = v;
        in_vec = vec;
        out_ready = rdy;
        zp_exp = v && q.size() == 0 && vec == 0;
        if (q.size() != 0 && rdy) begin
            void'(q.pop_front());
            seq++;
        end else if (v && q.size() == 0) begin
            seq = 0;
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
            for (int i = 7; i >= 0; i--) if (vec[i]) q.push_back(i);
`else
            for (int i = 0; i < 8; i++) if (vec[i]) q.push_back(i);
`endif
        end
    endtask

    initial begin
        logic [7:0] rv;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_seq", out_seq, 0);
        check("rst_zero_pulse", zero_pulse, 0);
        rst = 0;
        model_clear();
        step(1, 8'h20, 1);
        repeat (3) step(0, 0, 1);
        step(1, 8'h8A, 1);
        repeat (4) step(0, 0, 1);
        step(1, 8'hFF, 1);
        for (int i = 0; i < 26; i++) step(0, 0, i % 3 == 0);
        repeat (2) step(0, 0, 1);
        step(1, 8'h00, 1);
        repeat (3) step(0, 0, 1);
        step(1, 8'hF0, 1);
        step(0, 0, 1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_seq", out_seq, 0);
        check("async_out_idx", out_idx, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (4) step(0, 0, 1);
        repeat (1500) begin
            case ($urandom_range(0, 3))
                0: rv = 8'h00;
                1: rv = 8'(1 << $urandom_range(0, 7));
                default: rv = 8'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, rv, $urandom_range(0, 2) != 0);
        end
        repeat (20) step(0, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onehot_scan_encoder.md
Name: onehot_scan_encoder

Overview:
- Inverse of the team's n-to-2^n decoders: accepts an N-bit request vector and emits the binary index of each set bit, one per handshake, lowest index first.
- A single set bit behaves as a one-hot-to-binary encoder.
- A multi-bit vector is serialised into a stream of indices.
- Sits between decoder-driven select/request logic and consumers that need binary indices, with valid/ready flow control on both sides.

Parameters:
N, 8, request vector width; power of two, 2..64
W, $clog2(N), index width; derived, not overridden

Ports:
clk        input   1    rising-edge clock
rst        input   1    reset, asynchronous, active-high
in_valid   input   1    in_vec valid
in_ready   output  1    block can accept a vector
in_vec     input   N    request vector
out_valid  output  1    out_idx valid
out_ready  input   1    consumer accepts out_idx
out_idx    output  W    binary index of current set bit
out_last   output  1    out_idx is the final index of the current vector
out_seq    output  W+1  count of indices already emitted for the current vector
zero_pulse output  1    one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async assert, sync release): state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, out_seq=0, zero_pulse=0. in_ready=1 from the first clock after release.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept = in_valid&in_ready at an edge.
  - Accept with in_vec!=0: pending<=in_vec, out_seq<=0, go to SCAN.
  - Accept with in_vec==0: stay in IDLE, zero_pulse=1 for the next cycle only, nothing emitted.
- SCAN:
  - in_ready=0; a new vector is never accepted while scanning.
  - out_valid=1.
  - out_idx = index of the lowest set bit of pending.
  - out_last = (popcount(pending)==1).
  - Outputs come from registered pending, so there is no combinational path from in_* to out_*.
- Latency: vector accepted at edge k gives out_valid=1 in the cycle after edge k.
- Emit = out_valid&out_ready at an edge. On emit: clear that bit in pending, out_seq<=out_seq+1.
- Emit with out_last=1: go to IDLE, pending becomes 0, in_ready=1 in the next cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last and out_seq hold stable.
- Throughput: a vector with k set bits takes 1 accept cycle + k emit cycles. Back-to-back vectors have one IDLE cycle between the last emit and the next accept.
- out_seq width W+1 so the all-ones vector reaches N with no wrap. out_seq resets to 0 on each new accept.
- Reset mid-SCAN: remaining pending bits are discarded, outputs return to reset values immediately (async), no partial index is emitted after release.
- in_vec is ignored when not accepted. in_valid while in SCAN has no effect and need not be held.

Optional Feature:
- Macro: ONEHOT_SCAN_MSB_FIRST_EN.
- Defined: scan order reverses; out_idx is the highest set bit of pending. out_last, out_seq and handshakes are unchanged.
- Undefined (default): lowest-set-bit-first as above.

Test Plan:
- Reset then one-hot: in_vec=8'b0010_0000, out_ready=1 -> one beat: out_idx=5, out_last=1, out_seq=0. in_ready returns to 1 the next cycle.
- Multi-bit: in_vec=8'b1000_1010, out_ready=1 -> out_idx 1,3,7 on consecutive cycles. out_last only on idx 7. out_seq 0,1,2.
- Backpressure: in_vec=8'hFF, out_ready toggled 1,0,0,1,... -> out_idx holds during stalls. All indices 0..7 emitted exactly once in order. out_seq reaches 7 on the last beat.
- Zero vector: in_vec=0 accepted -> zero_pulse=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- Reset mid-scan: in_vec=8'hF0, assert rst asynchronously after idx 4 is emitted -> out_valid drops without a clock, no idx 5..7 after release, in_ready=1 after release.
- With ONEHOT_SCAN_MSB_FIRST_EN: in_vec=8'b1000_1010 -> out_idx 7,3,1, out_last on idx 1.
